rgbw_fade_ramp: RTL and testbench

Slew-rate limiter between the colour generator and the four-channel PWM generator. It accepts new RGBW target duties and moves the duties it presents to the PWM stage one LSB at a time toward those targets, at a programmable rate. This gives smooth fades instead of step changes in light output. A per-channel slew sub-unit does the stepping, and a shared prescaled step tick drives all four channels.

---
 rtl/rgbw_pkg.sv | 14 +
 rtl/rgbw_slew_chan.sv | 56 +++++
 rtl/rgbw_fade_ramp.sv | 112 +++++++++++
 tb/tb_rgbw_fade_ramp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW fade ramp: duty width, default prescaler
// divisor and the ramp FSM state encoding.
package rgbw_pkg;

    localparam int DUTY_W       = 8;
    localparam int RATE_W       = 8;
    localparam int STEP_DIV_DEF = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

endpackage

// File: rtl/rgbw_slew_chan.sv
// One colour channel of the fade ramp: a latched target and the duty that
// walks toward it one LSB per step. at_target_o looks at the values this
// channel will hold after the current edge, so the top can end the ramp on
// the same edge the final duty update lands.
module rgbw_slew_chan
    import rgbw_pkg::*;
#(
    parameter int W = DUTY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         bypass_i,
    input  logic         step_i,
    input  logic [W-1:0] target_i,
    output logic [W-1:0] duty_o,
    output logic         at_target_o
);

    logic [W-1:0] tgt_q, tgt_d;
    logic [W-1:0] duty_q, duty_d;

    // A load captures a new target (and jumps in bypass); otherwise a step
    // moves the duty one LSB toward the target, never past it.
    always_comb begin
        tgt_d  = tgt_q;
        duty_d = duty_q;
        if (load_i) begin
            tgt_d = target_i;
            if (bypass_i) begin
                duty_d = target_i;
            end
        end else if (step_i) begin
            if (duty_q < tgt_q) begin
                duty_d = duty_q + W'(1);
            end else if (duty_q > tgt_q) begin
                duty_d = duty_q - W'(1);
            end
        end
    end

    // Target and duty registers; reset leaves the channel dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q  <= '0;
            duty_q <= '0;
        end else begin
            tgt_q  <= tgt_d;
            duty_q <= duty_d;
        end
    end

    assign duty_o      = duty_q;
    assign at_target_o = (duty_d == tgt_d);

endmodule

// File: rtl/rgbw_fade_ramp.sv
// Slew-rate limiter feeding the RGBW PWM stage. A shared prescaler and rate
// counter produce a step strobe that moves all four channel duties one LSB
// toward their latched targets; busy/done report the ramp status.
module rgbw_fade_ramp
    import rgbw_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEF,
    parameter int W        = DUTY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      target_r,
    input  logic [W-1:0]      target_g,
    input  logic [W-1:0]      target_b,
    input  logic [W-1:0]      target_w,
    input  logic [RATE_W-1:0] rate,
    input  logic              load,
    output logic [W-1:0]      duty_r,
    output logic [W-1:0]      duty_g,
    output logic [W-1:0]      duty_b,
    output logic [W-1:0]      duty_w,
    output logic              busy,
    output logic              done
);

    localparam int PW = $clog2(STEP_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [RATE_W-1:0] rcnt_q, rcnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              done_q, done_d;

    logic              bypass;
    logic              tick;
    logic              step;
    logic              allAt;
    logic [3:0]        chanAt;

    assign bypass = (rate == '0);
    assign tick   = (state_q == RAMP) && (presc_q == PRESC_MAX);
    assign step   = tick && (rcnt_q == rate_q - RATE_W'(1));
    assign allAt  = &chanAt;

    rgbw_slew_chan #(.W(W)) u_chan_r (
        .clk(clk), .rst_n(rst_n), .load_i(load), .bypass_i(bypass), .step_i(step),
        .target_i(target_r), .duty_o(duty_r), .at_target_o(chanAt[0])
    );
    rgbw_slew_chan #(.W(W)) u_chan_g (
        .clk(clk), .rst_n(rst_n), .load_i(load), .bypass_i(bypass), .step_i(step),
        .target_i(target_g), .duty_o(duty_g), .at_target_o(chanAt[1])
    );
    rgbw_slew_chan #(.W(W)) u_chan_b (
        .clk(clk), .rst_n(rst_n), .load_i(load), .bypass_i(bypass), .step_i(step),
        .target_i(target_b), .duty_o(duty_b), .at_target_o(chanAt[2])
    );
    rgbw_slew_chan #(.W(W)) u_chan_w (
        .clk(clk), .rst_n(rst_n), .load_i(load), .bypass_i(bypass), .step_i(step),
        .target_i(target_w), .duty_o(duty_w), .at_target_o(chanAt[3])
    );

    // Next-state logic: loads restart the step timing, RAMP runs the
    // prescaler/rate counter, and the ramp ends when every channel lands.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        rcnt_d  = '0;
        rate_d  = rate_q;
        done_d  = 1'b0;
        if (load) begin
            rate_d = rate;
            if (bypass || allAt) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RAMP;
            end
        end else if (state_q == RAMP) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            rcnt_d  = rcnt_q;
            if (tick) begin
                rcnt_d = step ? '0 : rcnt_q + RATE_W'(1);
            end
            if (step && allAt) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // Control registers; reset returns the block to an idle, dark state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            rcnt_q  <= '0;
            rate_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rcnt_q  <= rcnt_d;
            rate_q  <= rate_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RAMP);
    assign done = done_q;

endmodule

// File: tb/tb_rgbw_fade_ramp.sv
// Self-checking bench for rgbw_fade_ramp with STEP_DIV = 4. Each load pushes
// the expected per-cycle outputs (closed-form fade) onto a scoreboard that is
// drained and compared once per cycle on the falling edge.
module tb_rgbw_fade_ramp;

    localparam int SD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] target_r, target_g, target_b, target_w;
    logic [7:0] rate;
    logic       load;
    logic [7:0] duty_r, duty_g, duty_b, duty_w;
    logic       busy, done;

    typedef struct {
        string       tag;
        int          k;
        logic [33:0] vec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] curR = 8'h00, curG = 8'h00, curB = 8'h00, curW = 8'h00;

    rgbw_fade_ramp #(.STEP_DIV(SD), .W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .target_r(target_r), .target_g(target_g), .target_b(target_b), .target_w(target_w),
        .rate(rate), .load(load),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_w(duty_w),
        .busy(busy), .done(done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Duty expected k edges after the load edge for a fade of s -> t.
    function automatic logic [7:0] fadeVal(input logic [7:0] s, input logic [7:0] t,
                                           input int k, input int period);
        int d;
        int n;
        d = (t > s) ? int'(t) - int'(s) : int'(s) - int'(t);
        n = k / period;
        if (n >= d) return t;
        if (t > s) return s + 8'(n);
        return s - 8'(n);
    endfunction

    function automatic int absDiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
    endfunction

    // Push expectations for k = 0..nChk, then drive a one-cycle load and
    // return on the falling edge after the load edge (k = 0 sample point).
    task automatic applyStimulus(input logic [7:0] tr, input logic [7:0] tg,
                                 input logic [7:0] tb, input logic [7:0] tw,
                                 input logic [7:0] rt, input int nChk, input string tag);
        int period;
        int maxd;
        int total;
        exp_t e;
        logic [7:0] er, eg, eb, ew;
        period = int'(rt) * SD;
        maxd = absDiff(curR, tr);
        if (absDiff(curG, tg) > maxd) maxd = absDiff(curG, tg);
        if (absDiff(curB, tb) > maxd) maxd = absDiff(curB, tb);
        if (absDiff(curW, tw) > maxd) maxd = absDiff(curW, tw);
        total = maxd * period;
        er = tr; eg = tg; eb = tb; ew = tw;
        for (int k = 0; k <= nChk; k++) begin
            e.tag = tag;
            e.k   = k;
            if (rt == 8'd0 || total == 0) begin
                e.vec = {tr, tg, tb, tw, 1'b0, (k == 0)};
            end else begin
                er = fadeVal(curR, tr, k, period);
                eg = fadeVal(curG, tg, k, period);
                eb = fadeVal(curB, tb, k, period);
                ew = fadeVal(curW, tw, k, period);
                e.vec = {er, eg, eb, ew, (k < total), (k == total)};
            end
            sb.push_back(e);
        end
        curR = er; curG = eg; curB = eb; curW = ew;
        target_r = tr; target_g = tg; target_b = tb; target_w = tw;
        rate = rt;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        target_r = 8'($urandom);
        target_g = 8'($urandom);
        target_b = 8'($urandom);
        target_w = 8'($urandom);
        rate     = 8'($urandom);
    endtask

    // Pop one scoreboard entry and compare against the live outputs.
    task automatic checkOutput();
        exp_t e;
        logic [33:0] obs;
        e = sb.pop_front();
        obs = {duty_r, duty_g, duty_b, duty_w, busy, done};
        checks++;
        assert (obs === e.vec) else begin
            errors++;
            $error("[TB] FAIL %s k=%0d observed rgbw/busy/done=%h/%b/%b expected=%h/%b/%b",
                   e.tag, e.k, obs[33:2], obs[1], obs[0], e.vec[33:2], e.vec[1], e.vec[0]);
        end
    endtask

    // Drain the scoreboard one cycle at a time; ends on the last sample edge.
    task automatic drain();
        while (sb.size() > 0) begin
            checkOutput();
            if (sb.size() > 0) @(negedge clk);
        end
    endtask

    // Direct comparison of all outputs against zero (idle / reset state).
    task automatic checkIdle(input string tag);
        logic [33:0] obs;
        obs = {duty_r, duty_g, duty_b, duty_w, busy, done};
        checks++;
        assert (obs === 34'd0) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=0", tag, obs);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        rate = 8'd0;
        target_r = 8'd0; target_g = 8'd0; target_b = 8'd0; target_w = 8'd0;
        #1;
        checkIdle("reset_asserted");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset idle");
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            target_r = 8'($urandom);
            rate     = 8'($urandom);
            if (i % 100 == 99) checkIdle("idle_no_load");
        end

        $display("[TB] bypass jump");
        applyStimulus(8'h80, 8'hFF, 8'h01, 8'h00, 8'd0, 5, "bypass");
        drain();

        $display("[TB] basic fade");
        @(negedge clk);
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'd0, 1, "bypass_zero");
        drain();
        @(negedge clk);
        applyStimulus(8'h05, 8'h00, 8'h00, 8'h00, 8'd2, 43, "fade_r5");
        drain();

        $display("[TB] mixed directions");
        @(negedge clk);
        applyStimulus(8'h10, 8'h00, 8'h00, 8'h00, 8'd0, 1, "bypass_r10");
        drain();
        @(negedge clk);
        applyStimulus(8'h0C, 8'h02, 8'h00, 8'h00, 8'd1, 19, "mixed");
        drain();

        $display("[TB] retarget and no-op load");
        @(negedge clk);
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'd0, 1, "bypass_zero2");
        drain();
        @(negedge clk);
        applyStimulus(8'h05, 8'h00, 8'h00, 8'h00, 8'd2, 28, "fade_partial");
        drain();
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'd2, 27, "retarget");
        drain();
        @(negedge clk);
        applyStimulus(curR, curG, curB, curW, 8'd3, 5, "noop_load");
        drain();

        $display("[TB] reset mid-ramp");
        @(negedge clk);
        applyStimulus(8'h05, 8'h00, 8'h00, 8'h00, 8'd2, 20, "fade_pre_reset");
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("async_reset_mid_ramp");
        @(negedge clk);
        checkIdle("held_in_reset");
        rst_n = 1'b1;
        curR = 8'h00; curG = 8'h00; curB = 8'h00; curW = 8'h00;
        @(negedge clk);
        applyStimulus(8'h05, 8'h00, 8'h00, 8'h00, 8'd2, 43, "fade_after_reset");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
